// File: rtl/seq_adder_n.sv
// Multi-cycle chunked ripple adder: a + b + c_in, CHUNK bits per clock,
// least significant chunk first, with valid/ready on both sides.
module seq_adder_n #(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic         o_valid,
    input  logic         o_ready,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         overflow
);

    localparam int NCHUNK = N / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [N-1:0]   sum_q, sum_d;
    logic           carry_q, carry_d;
    logic [KW-1:0]  k_q, k_d;
    logic           c_out_q, c_out_d;
    logic           ovf_q, ovf_d;

    logic [CHUNK:0] chunk_r;
    logic [N-1:0]   chunk_ext;
    logic           last;

    // Operands shift right each BUSY cycle so the active chunk is always
    // at the bottom; sum fills from the top and lands aligned after NCHUNK.
    always_comb begin
        chunk_r = {1'b0, a_q[CHUNK-1:0]}
                + {1'b0, b_q[CHUNK-1:0]}
                + {{CHUNK{1'b0}}, carry_q};
        chunk_ext = N'(chunk_r[CHUNK-1:0]);
        last = (k_q == KW'(NCHUNK - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        k_d     = k_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (i_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = c_in;
                    k_d     = '0;
                    sum_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                sum_d   = (sum_q >> CHUNK) | (chunk_ext << (N - CHUNK));
                carry_d = chunk_r[CHUNK];
                k_d     = k_q + KW'(1);
                if (last) begin
                    c_out_d = chunk_r[CHUNK];
                    // carry into the MSB recovered from the MSB sum bit
                    ovf_d   = a_q[CHUNK-1] ^ b_q[CHUNK-1]
                            ^ chunk_r[CHUNK-1] ^ chunk_r[CHUNK];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (o_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign i_ready  = (state_q == IDLE);
    assign o_valid  = (state_q == DONE);
    assign sum      = sum_q;
    assign c_out    = c_out_q;
    assign overflow = ovf_q;

endmodule
